// File: rtl/iir_filter_multich.sv
// First-order IIR low-pass shared across N_CH time-interleaved channels.
// Every channel keeps its own x[n-1]/y[n-1] state. The coefficients are
// double-buffered: writes land in a shadow set, which is promoted to the
// active set only at the start of a frame (a channel-0 sample).
module iir_filter_multich #(
  parameter int DATA_W        = 64,
  parameter int COEF_W        = 16,
  parameter int N_CH          = 4,
  parameter int LOG2A1        = 8,
  parameter int FIFO_DEPTH    = 2048,
  parameter int START_SENDING = 0
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic                                    clear,
  input  logic                                    bypass,
  input  logic                                    coef_wr,
  input  logic signed [COEF_W-1:0]                coef_b1,
  input  logic signed [COEF_W-1:0]                coef_b2,
  input  logic signed [COEF_W-1:0]                coef_a2,
  input  logic                                    data_valid,
  input  logic signed [DATA_W-1:0]                data,
  output logic signed [DATA_W-1:0]                data_out,
  output logic                                    data_out_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] data_out_ch,
  output logic                                    saturated,
  output logic                                    ready,
  output logic                                    fifo_lleno
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int N_SLOT  = 2 ** CH_W;
  localparam int PW      = DATA_W + COEF_W;
  localparam int SW      = PW + 2;
  localparam int LIMIT_I = FIFO_DEPTH + START_SENDING;
  localparam int CNT_W   = $clog2(LIMIT_I + 1);

  localparam logic [CNT_W-1:0]         CNT_LIMIT = CNT_W'(LIMIT_I);
  localparam logic [CH_W-1:0]          CH_LAST   = CH_W'(N_CH - 1);
  localparam logic signed [COEF_W-1:0] DEF_B1    = COEF_W'(4);
  localparam logic signed [COEF_W-1:0] DEF_B2    = COEF_W'(4);
  localparam logic signed [COEF_W-1:0] DEF_A2    = COEF_W'(-248);
  localparam logic signed [SW-1:0]     SAT_MAX   = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     SAT_MIN   = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // State registers and their next-state values
  logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
  logic [CNT_W-1:0]         counter_q, counter_d;
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic                     data_out_valid_q, data_out_valid_d;
  logic [CH_W-1:0]          data_out_ch_q, data_out_ch_d;
  logic                     saturated_q, saturated_d;
  logic                     fifo_lleno_q, fifo_lleno_d;
  logic signed [DATA_W-1:0] x_state_q [N_SLOT];
  logic signed [DATA_W-1:0] x_state_d [N_SLOT];
  logic signed [DATA_W-1:0] y_state_q [N_SLOT];
  logic signed [DATA_W-1:0] y_state_d [N_SLOT];
  logic signed [COEF_W-1:0] b1_sh_q, b1_sh_d, b2_sh_q, b2_sh_d, a2_sh_q, a2_sh_d;
  logic signed [COEF_W-1:0] b1_act_q, b1_act_d, b2_act_q, b2_act_d, a2_act_q, a2_act_d;

  // Datapath signals
  logic                     accept;
  logic                     load_coefs;
  logic                     warm_done;
  logic signed [COEF_W-1:0] b1_eff, b2_eff, a2_eff;
  logic signed [PW-1:0]     x_ext, xp_ext, yp_ext, b1_ext, b2_ext, a2_ext;
  logic signed [PW-1:0]     prod_b1, prod_b2, prod_a2;
  logic signed [SW-1:0]     sum, shifted;
  logic signed [DATA_W-1:0] y_sat;
  logic                     sat_hit;
  logic [CNT_W-1:0]         counter_inc;

  // With no warm-up configured every output is qualified from the start
  if (START_SENDING == 0) begin : g_no_warm
    assign warm_done = 1'b1;
  end else begin : g_warm
    assign warm_done = (counter_q >= CNT_W'(START_SENDING));
  end

  // Filter arithmetic for the current channel; a frame-start sample sees the shadow set directly
  always_comb begin
    accept     = enable && data_valid && !clear;
    load_coefs = accept && (ch_idx_q == '0);
    b1_eff     = load_coefs ? b1_sh_q : b1_act_q;
    b2_eff     = load_coefs ? b2_sh_q : b2_act_q;
    a2_eff     = load_coefs ? a2_sh_q : a2_act_q;
    x_ext      = $signed({{COEF_W{data[DATA_W-1]}}, data});
    xp_ext     = $signed({{COEF_W{x_state_q[ch_idx_q][DATA_W-1]}}, x_state_q[ch_idx_q]});
    yp_ext     = $signed({{COEF_W{y_state_q[ch_idx_q][DATA_W-1]}}, y_state_q[ch_idx_q]});
    b1_ext     = $signed({{DATA_W{b1_eff[COEF_W-1]}}, b1_eff});
    b2_ext     = $signed({{DATA_W{b2_eff[COEF_W-1]}}, b2_eff});
    a2_ext     = $signed({{DATA_W{a2_eff[COEF_W-1]}}, a2_eff});
    prod_b1    = x_ext * b1_ext;
    prod_b2    = xp_ext * b2_ext;
    prod_a2    = yp_ext * a2_ext;
    sum        = $signed({{2{prod_b1[PW-1]}}, prod_b1})
               + $signed({{2{prod_b2[PW-1]}}, prod_b2})
               - $signed({{2{prod_a2[PW-1]}}, prod_a2});
    shifted    = sum >>> LOG2A1;
    sat_hit    = 1'b0;
    if (shifted > SAT_MAX) begin
      y_sat   = {1'b0, {(DATA_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      y_sat   = {1'b1, {(DATA_W-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      y_sat   = shifted[DATA_W-1:0];
    end
    counter_inc = (counter_q == CNT_LIMIT) ? counter_q : counter_q + CNT_W'(1);
  end

  // Next-state logic: clear beats a simultaneous sample, coefficient writes are always captured
  always_comb begin
    ch_idx_d         = ch_idx_q;
    counter_d        = counter_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    data_out_ch_d    = data_out_ch_q;
    saturated_d      = saturated_q;
    fifo_lleno_d     = fifo_lleno_q;
    x_state_d        = x_state_q;
    y_state_d        = y_state_q;
    b1_sh_d          = b1_sh_q;
    b2_sh_d          = b2_sh_q;
    a2_sh_d          = a2_sh_q;
    b1_act_d         = b1_act_q;
    b2_act_d         = b2_act_q;
    a2_act_d         = a2_act_q;

    if (coef_wr) begin
      b1_sh_d = coef_b1;
      b2_sh_d = coef_b2;
      a2_sh_d = coef_a2;
    end

    if (clear) begin
      for (int i = 0; i < N_SLOT; i++) begin
        x_state_d[i] = '0;
        y_state_d[i] = '0;
      end
      ch_idx_d     = '0;
      counter_d    = '0;
      saturated_d  = 1'b0;
      fifo_lleno_d = 1'b0;
    end else if (accept) begin
      if (load_coefs) begin
        b1_act_d = b1_sh_q;
        b2_act_d = b2_sh_q;
        a2_act_d = a2_sh_q;
      end
      data_out_d            = bypass ? data : y_sat;
      data_out_ch_d         = ch_idx_q;
      data_out_valid_d      = warm_done;
      x_state_d[ch_idx_q]   = data;
      y_state_d[ch_idx_q]   = y_sat;
      if (!bypass && sat_hit) begin
        saturated_d = 1'b1;
      end
      ch_idx_d     = (ch_idx_q == CH_LAST) ? '0 : ch_idx_q + CH_W'(1);
      counter_d    = counter_inc;
      fifo_lleno_d = (counter_inc == CNT_LIMIT);
    end
  end

  // Register update with synchronous active-low reset back to default coefficients
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SLOT; i++) begin
        x_state_q[i] <= '0;
        y_state_q[i] <= '0;
      end
      ch_idx_q         <= '0;
      counter_q        <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      data_out_ch_q    <= '0;
      saturated_q      <= 1'b0;
      fifo_lleno_q     <= 1'b0;
      b1_sh_q          <= DEF_B1;
      b2_sh_q          <= DEF_B2;
      a2_sh_q          <= DEF_A2;
      b1_act_q         <= DEF_B1;
      b2_act_q         <= DEF_B2;
      a2_act_q         <= DEF_A2;
    end else begin
      x_state_q        <= x_state_d;
      y_state_q        <= y_state_d;
      ch_idx_q         <= ch_idx_d;
      counter_q        <= counter_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      data_out_ch_q    <= data_out_ch_d;
      saturated_q      <= saturated_d;
      fifo_lleno_q     <= fifo_lleno_d;
      b1_sh_q          <= b1_sh_d;
      b2_sh_q          <= b2_sh_d;
      a2_sh_q          <= a2_sh_d;
      b1_act_q         <= b1_act_d;
      b2_act_q         <= b2_act_d;
      a2_act_q         <= a2_act_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign data_out_ch    = data_out_ch_q;
  assign saturated      = saturated_q;
  assign fifo_lleno     = fifo_lleno_q;
  assign ready          = reset;

endmodule

// File: tb/tb_iir_filter_multich.sv
// Bench for iir_filter_multich. Two instances: dut_a is a 4-channel 64-bit
// filter with a short warm-up and FIFO threshold, dut_b a 1-channel 16-bit
// filter used for the step response and saturation. A per-channel golden
// model pushes expected outputs into a queue; a monitor pops and compares.
module tb_iir_filter_multich;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // dut_a signals
  logic               reset_a, enable_a, clear_a, bypass_a, coef_wr_a, data_valid_a;
  logic signed [15:0] coef_b1_a, coef_b2_a, coef_a2_a;
  logic signed [63:0] data_a, data_out_a;
  logic               data_out_valid_a, saturated_a, ready_a, fifo_lleno_a;
  logic [1:0]         data_out_ch_a;

  // dut_b signals
  logic               reset_b, enable_b, clear_b, bypass_b, coef_wr_b, data_valid_b;
  logic signed [15:0] coef_b1_b, coef_b2_b, coef_a2_b;
  logic signed [15:0] data_b, data_out_b;
  logic               data_out_valid_b, saturated_b, ready_b, fifo_lleno_b;
  logic [0:0]         data_out_ch_b;

  iir_filter_multich #(
    .DATA_W(64), .COEF_W(16), .N_CH(4), .LOG2A1(8), .FIFO_DEPTH(5), .START_SENDING(3)
  ) dut_a (
    .clock(clock), .reset(reset_a), .enable(enable_a), .clear(clear_a), .bypass(bypass_a),
    .coef_wr(coef_wr_a), .coef_b1(coef_b1_a), .coef_b2(coef_b2_a), .coef_a2(coef_a2_a),
    .data_valid(data_valid_a), .data(data_a), .data_out(data_out_a),
    .data_out_valid(data_out_valid_a), .data_out_ch(data_out_ch_a), .saturated(saturated_a),
    .ready(ready_a), .fifo_lleno(fifo_lleno_a)
  );

  iir_filter_multich #(
    .DATA_W(16), .COEF_W(16), .N_CH(1), .LOG2A1(8), .FIFO_DEPTH(2048), .START_SENDING(0)
  ) dut_b (
    .clock(clock), .reset(reset_b), .enable(enable_b), .clear(clear_b), .bypass(bypass_b),
    .coef_wr(coef_wr_b), .coef_b1(coef_b1_b), .coef_b2(coef_b2_b), .coef_a2(coef_a2_b),
    .data_valid(data_valid_b), .data(data_b), .data_out(data_out_b),
    .data_out_valid(data_out_valid_b), .data_out_ch(data_out_ch_b), .saturated(saturated_b),
    .ready(ready_b), .fifo_lleno(fifo_lleno_b)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  ch;
  } exp_a_t;

  exp_a_t      q_a[$];
  logic [15:0] q_b[$];

  // Golden model state
  logic signed [63:0] ma_x[4], ma_y[4];
  logic signed [15:0] ma_sh[3], ma_act[3];
  int                 ma_ch, ma_cnt;
  logic signed [15:0] mb_x, mb_y;
  logic signed [15:0] mb_sh[3], mb_act[3];
  bit                 mb_sat;

  // Wide reference arithmetic, floor shift and clamp to dw bits
  function automatic logic signed [127:0] iir_model(
    input logic signed [127:0] x, xp, yp, b1, b2, a2, input int dw, output bit sat);
    logic signed [127:0] acc, hi, lo, one;
    one = 128'sd1;
    acc = (b1 * x + b2 * xp - a2 * yp) >>> 8;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    sat = 1'b0;
    if (acc > hi) begin
      acc = hi;
      sat = 1'b1;
    end else if (acc < lo) begin
      acc = lo;
      sat = 1'b1;
    end
    return acc;
  endfunction

  task automatic model_reset_a();
    for (int i = 0; i < 4; i++) begin
      ma_x[i] = '0;
      ma_y[i] = '0;
    end
    ma_sh  = '{16'sd4, 16'sd4, -16'sd248};
    ma_act = '{16'sd4, 16'sd4, -16'sd248};
    ma_ch  = 0;
    ma_cnt = 0;
  endtask

  task automatic model_reset_b();
    mb_x   = '0;
    mb_y   = '0;
    mb_sh  = '{16'sd4, 16'sd4, -16'sd248};
    mb_act = '{16'sd4, 16'sd4, -16'sd248};
    mb_sat = 1'b0;
  endtask

  // One dut_a cycle: drive the sample, advance the model, push the expected output
  task automatic send_a(input logic signed [63:0] x, input bit wr = 1'b0,
                        input logic signed [15:0] nb1 = 0, input logic signed [15:0] nb2 = 0,
                        input logic signed [15:0] na2 = 0);
    logic signed [127:0] y;
    bit s;
    int c;
    exp_a_t e;
    @(negedge clock);
    data_a = x; data_valid_a = 1'b1; coef_wr_a = wr;
    coef_b1_a = nb1; coef_b2_a = nb2; coef_a2_a = na2;
    if (enable_a && !clear_a) begin
      c = ma_ch;
      if (c == 0) ma_act = ma_sh;
      y = iir_model(x, ma_x[c], ma_y[c], ma_act[0], ma_act[1], ma_act[2], 64, s);
      e.d  = bypass_a ? x : y[63:0];
      e.ch = c[1:0];
      if (ma_cnt >= 3) q_a.push_back(e);
      ma_x[c] = x;
      ma_y[c] = y[63:0];
      if (ma_cnt < 8) ma_cnt++;
      ma_ch = (c + 1) % 4;
    end
    if (wr) ma_sh = '{nb1, nb2, na2};
    @(posedge clock);
    #1;
    data_valid_a = 1'b0;
    coef_wr_a    = 1'b0;
  endtask

  task automatic send_b(input logic signed [15:0] x, input bit wr = 1'b0,
                        input logic signed [15:0] nb1 = 0, input logic signed [15:0] nb2 = 0,
                        input logic signed [15:0] na2 = 0);
    logic signed [127:0] y;
    bit s;
    @(negedge clock);
    data_b = x; data_valid_b = 1'b1; coef_wr_b = wr;
    coef_b1_b = nb1; coef_b2_b = nb2; coef_a2_b = na2;
    if (enable_b && !clear_b) begin
      mb_act = mb_sh;
      y = iir_model(x, mb_x, mb_y, mb_act[0], mb_act[1], mb_act[2], 16, s);
      q_b.push_back(bypass_b ? x : y[15:0]);
      if (s && !bypass_b) mb_sat = 1'b1;
      mb_x = x;
      mb_y = y[15:0];
    end
    if (wr) mb_sh = '{nb1, nb2, na2};
    @(posedge clock);
    #1;
    data_valid_b = 1'b0;
    coef_wr_b    = 1'b0;
  endtask

  // Scoreboard monitors: every qualified output must match the oldest expected entry
  always @(negedge clock) begin
    exp_a_t e;
    if (data_out_valid_a === 1'b1) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_a_unexpected: got data=%0d ch=%0d, required no output", data_out_a, data_out_ch_a);
      end else begin
        e = q_a.pop_front();
        if ({data_out_a, data_out_ch_a} !== {e.d, e.ch}) begin
          n_fail++;
          $display("[TB] FAIL sb_a: got data=%0d ch=%0d, required data=%0d ch=%0d",
                   data_out_a, data_out_ch_a, $signed(e.d), e.ch);
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [15:0] e;
    if (data_out_valid_b === 1'b1) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_b_unexpected: got data=%0d, required no output", data_out_b);
      end else begin
        e = q_b.pop_front();
        if (data_out_b !== e) begin
          n_fail++;
          $display("[TB] FAIL sb_b: got %0d, required %0d", data_out_b, $signed(e));
        end
      end
    end
  end

  task automatic test_reset();
    reset_a = 1'b0; enable_a = 1'b1; clear_a = 1'b0; bypass_a = 1'b0; coef_wr_a = 1'b0;
    data_valid_a = 1'b0; data_a = '0; coef_b1_a = '0; coef_b2_a = '0; coef_a2_a = '0;
    reset_b = 1'b0; enable_b = 1'b1; clear_b = 1'b0; bypass_b = 1'b0; coef_wr_b = 1'b0;
    data_valid_b = 1'b0; data_b = '0; coef_b1_b = '0; coef_b2_b = '0; coef_a2_b = '0;
    model_reset_a();
    model_reset_b();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({data_out_a, data_out_valid_a, data_out_ch_a, saturated_a, fifo_lleno_a, ready_a} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got out=%0d v=%b ch=%0d sat=%b full=%b rdy=%b, required all 0",
               data_out_a, data_out_valid_a, data_out_ch_a, saturated_a, fifo_lleno_a, ready_a);
    end
    n_checks++;
    if ({data_out_b, data_out_valid_b, saturated_b, ready_b} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got out=%0d v=%b sat=%b rdy=%b, required all 0",
               data_out_b, data_out_valid_b, saturated_b, ready_b);
    end
    @(negedge clock);
    reset_a = 1'b1;
    reset_b = 1'b1;
    #1;
    n_checks++;
    if ({ready_a, ready_b} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b%b, required 11", ready_a, ready_b);
    end
  endtask

  // First three outputs are warm-up; the FIFO flag rises with the eighth sample
  task automatic test_warmup_fifo();
    int pat[4] = '{1000, -1000, 0, 500};
    for (int i = 0; i < 8; i++) begin
      send_a(pat[i % 4]);
      n_checks++;
      if (data_out_valid_a !== (i >= 3)) begin
        n_fail++;
        $display("[TB] FAIL warmup_valid[%0d]: got %b, required %b", i, data_out_valid_a, (i >= 3));
      end
      n_checks++;
      if (fifo_lleno_a !== (i == 7)) begin
        n_fail++;
        $display("[TB] FAIL fifo_lleno[%0d]: got %b, required %b", i, fifo_lleno_a, (i == 7));
      end
      n_checks++;
      if (data_out_ch_a !== 2'(i % 4)) begin
        n_fail++;
        $display("[TB] FAIL warmup_ch[%0d]: got %0d, required %0d", i, data_out_ch_a, i % 4);
      end
    end
  endtask

  task automatic test_multich();
    for (int f = 0; f < 60; f++) begin
      send_a(1000);
      send_a(-1000);
      send_a(0);
      send_a(500);
    end
    n_checks++;
    if ({fifo_lleno_a, saturated_a} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL multich_flags: got full=%b sat=%b, required full=1 sat=0", fifo_lleno_a, saturated_a);
    end
  endtask

  // New coefficients written alongside the ch2 sample; inputs step so old and new sets differ
  task automatic test_coef_switch();
    send_a(1000);
    send_a(-1000);
    send_a(2000, 1'b1, 16'sd8, 16'sd8, -16'sd240);
    send_a(-3000);
    for (int f = 0; f < 10; f++) begin
      send_a(1000);
      send_a(-1000);
      send_a(2000);
      send_a(-3000);
    end
  endtask

  task automatic test_bypass();
    logic signed [63:0] x;
    bypass_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom};
      send_a(x);
      n_checks++;
      if (data_out_a !== x) begin
        n_fail++;
        $display("[TB] FAIL bypass[%0d]: got %0d, required %0d", i, data_out_a, x);
      end
    end
    bypass_a = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send_a(300);
      send_a(-700);
      send_a(1500);
      send_a(42);
    end
  endtask

  // Disabled cycles neither accept nor emit, but still capture a coefficient write
  task automatic test_enable();
    logic signed [63:0] held;
    held = data_out_a;
    enable_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_a(777, k == 1, 16'sd2, 16'sd2, -16'sd252);
      n_checks++;
      if (data_out_valid_a !== 1'b0 || data_out_a !== held) begin
        n_fail++;
        $display("[TB] FAIL enable_off[%0d]: got v=%b out=%0d, required v=0 out=%0d",
                 k, data_out_valid_a, data_out_a, held);
      end
    end
    enable_a = 1'b1;
    send_a(1000);
    n_checks++;
    if (data_out_ch_a !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL enable_resume_ch: got %0d, required 0", data_out_ch_a);
    end
    send_a(-1000);
    send_a(2000);
    send_a(-3000);
  endtask

  task automatic test_reset_midframe();
    send_a(111);
    send_a(222);
    @(negedge clock);
    reset_a = 1'b0;
    #1;
    n_checks++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ready_in_reset: got %b, required 0", ready_a);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if ({data_out_a, data_out_valid_a, data_out_ch_a, saturated_a, fifo_lleno_a} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got out=%0d v=%b ch=%0d sat=%b full=%b, required all 0",
               data_out_a, data_out_valid_a, data_out_ch_a, saturated_a, fifo_lleno_a);
    end
    model_reset_a();
    reset_a = 1'b1;
    send_a(1234);
    n_checks++;
    if (data_out_ch_a !== 2'd0 || data_out_valid_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_reset_first: got ch=%0d v=%b, required ch=0 v=0", data_out_ch_a, data_out_valid_a);
    end
    send_a(55);
    n_checks++;
    if (data_out_ch_a !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL after_reset_second_ch: got %0d, required 1", data_out_ch_a);
    end
    for (int i = 0; i < 6; i++) send_a(100 * i - 250);
  endtask

  // Truncating shift leaves the step settling slightly below 1000 (where (1000-y)/32 rounds to 0)
  task automatic test_step();
    int prev;
    prev = 0;
    for (int i = 0; i < 250; i++) begin
      send_b(1000);
      n_checks++;
      if (data_out_valid_b !== 1'b1 || $signed(data_out_b) < prev || $signed(data_out_b) > 1000) begin
        n_fail++;
        $display("[TB] FAIL step[%0d]: got v=%b y=%0d, required v=1 and %0d<=y<=1000",
                 i, data_out_valid_b, data_out_b, prev);
      end
      prev = $signed(data_out_b);
    end
    n_checks++;
    if (prev < 968) begin
      n_fail++;
      $display("[TB] FAIL step_final: got %0d, required 968..1000", prev);
    end
  endtask

  task automatic test_saturation_clear();
    send_b(1000, 1'b1, 16'sd256, 16'sd256, 16'sd0);
    send_b(32767);
    n_checks++;
    if (data_out_b !== 16'sd32767 || saturated_b !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sat_clamp: got y=%0d sat=%b, required y=32767 sat=1", data_out_b, saturated_b);
    end
    @(negedge clock);
    clear_b = 1'b1; data_valid_b = 1'b1; data_b = 16'sd5;
    mb_x = '0; mb_y = '0; mb_sat = 1'b0;
    @(posedge clock);
    #1;
    clear_b = 1'b0; data_valid_b = 1'b0;
    n_checks++;
    if (data_out_valid_b !== 1'b0 || saturated_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clear: got v=%b sat=%b, required v=0 sat=0", data_out_valid_b, saturated_b);
    end
    send_b(100);
    n_checks++;
    if (data_out_b !== 16'sd100 || saturated_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_clear: got y=%0d sat=%b, required y=100 sat=0", data_out_b, saturated_b);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_warmup_fifo();
    test_multich();
    test_coef_switch();
    test_bypass();
    test_enable();
    test_reset_midframe();
    test_step();
    test_saturation_clear();
    repeat (3) @(negedge clock);
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
